// File: rtl/jk_bank_driver.sv
// jk_bank_driver
//
// Sequences a bank of WIDTH external JK flip-flops to a requested target.
// A request is accepted in IDLE. The block registers a J/K excitation for
// one DRIVE cycle, and then checks the flops' Q feedback in a CHECK cycle.
// If the check fails, it drives again, up to MAX_RETRY extra times. It ends
// with a one-cycle done pulse on success, or a one-cycle err pulse when the
// retries are exhausted.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous, active-high reset
//   req_valid    request present
//   req_ready    high only in IDLE
//   req_target   desired flop value, sampled on accept
//   q_fb         Q outputs of the driven flop bank
//   j_out/k_out  registered J/K excitation to the flop bank
//   busy         high in DRIVE or CHECK
//   done         one-cycle pulse: target reached
//   err          one-cycle pulse: retries exhausted
//   retry_cnt    retries used by the current/last request

module jk_bank_driver #(
  parameter  int WIDTH      = 4,
  parameter  int MAX_RETRY  = 3,
  parameter  int USE_TOGGLE = 0,
  localparam int RCW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RCW-1:0]   retry_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [RCW-1:0] MAX_R = RCW'(MAX_RETRY);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
  logic [WIDTH-1:0] r_j, w_j_nxt;
  logic [WIDTH-1:0] r_k, w_k_nxt;
  logic [RCW-1:0]   r_retry, w_retry_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  // The excitation target is the incoming request on accept. On a retry, it
  // is the latched target.
  logic [WIDTH-1:0] w_exc_tgt;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_j_exc;
  logic [WIDTH-1:0] w_k_exc;

  assign w_exc_tgt = (r_state == IDLE) ? req_target : r_tgt;
  assign w_diff    = q_fb ^ w_exc_tgt;
  // Bits that already match get J=K=0 (hold). Bits that must change are
  // toggled, or are set/reset towards the target.
  assign w_j_exc   = (USE_TOGGLE != 0) ? w_diff : (w_diff & w_exc_tgt);
  assign w_k_exc   = (USE_TOGGLE != 0) ? w_diff : (w_diff & ~w_exc_tgt);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_retry_nxt = r_retry;
    w_j_nxt     = '0;
    w_k_nxt     = '0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_tgt_nxt   = req_target;
          w_retry_nxt = '0;
          w_j_nxt     = w_j_exc;
          w_k_nxt     = w_k_exc;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        // J/K fall back to zero through the defaults, so the flops hold in CHECK.
        w_state_nxt = CHECK;
      end
      CHECK: begin
        if (q_fb == r_tgt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_retry < MAX_R) begin
          w_retry_nxt = r_retry + RCW'(1);
          w_j_nxt     = w_j_exc;
          w_k_nxt     = w_k_exc;
          w_state_nxt = DRIVE;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: the reset is asynchronous, so it is in the sensitivity list. This
  // drops J/K and abandons any request without waiting for a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_tgt   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_retry <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register update from the
      // pre-edge values and prevent ordering races between processes.
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_retry <= w_retry_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state == DRIVE) || (r_state == CHECK);
  assign j_out     = r_j;
  assign k_out     = r_k;
  assign done      = r_done;
  assign err       = r_err;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver. Two instances share the request inputs.
// One uses set/reset excitation and the other uses toggle excitation. Each
// instance drives its own behavioural JK flop bank. A stuck-at-0 mask on
// bit 0 can be applied to both banks.

module tb_jk_bank_driver;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_target = '0;
  logic [W-1:0] stuck = '0;

  // Instance 0: USE_TOGGLE=0
  logic [W-1:0] q0, j0, k0;
  logic         ready0, busy0, done0, err0;
  logic [1:0]   retry0;
  // Instance 1: USE_TOGGLE=1
  logic [W-1:0] q1, j1, k1;
  logic         ready1, busy1, done1, err1;
  logic [1:0]   retry1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(3), .USE_TOGGLE(0)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(ready0),
    .req_target(req_target), .q_fb(q0), .j_out(j0), .k_out(k0),
    .busy(busy0), .done(done0), .err(err0), .retry_cnt(retry0)
  );

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(3), .USE_TOGGLE(1)) dut_t (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(ready1),
    .req_target(req_target), .q_fb(q1), .j_out(j1), .k_out(k1),
    .busy(busy1), .done(done1), .err(err1), .retry_cnt(retry1)
  );

  // Behavioural JK flop banks on the same clock. Q+ = J&~Q | ~K&Q
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      q0 <= ((j0 & ~q0) | (~k0 & q0)) & ~stuck;
      q1 <= ((j1 & ~q1) | (~k1 & q1)) & ~stuck;
    end
  end

  // Advance one rising edge and settle. Inputs are driven and outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    // Reset applied from time zero.
    tick();
    n_total++; if (j0 !== 4'b0000 || k0 !== 4'b0000) $display("FAIL reset_jk: j=%b k=%b want 0000/0000", j0, k0); else n_pass++;
    n_total++; if ({busy0, done0, err0} !== 3'b000) $display("FAIL reset_flags: busy/done/err=%b want 000", {busy0, done0, err0}); else n_pass++;
    n_total++; if (retry0 !== 2'd0) $display("FAIL reset_retry: got %0d want 0", retry0); else n_pass++;
    RST = 1'b0;
    tick();
    n_total++; if (ready0 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready0); else n_pass++;
    // Start a request, then abort it asynchronously in the middle of DRIVE.
    req_valid = 1'b1; req_target = 4'b1111;
    tick();
    req_valid = 1'b0;
    n_total++; if (busy0 !== 1'b1 || j0 !== 4'b1111) $display("FAIL reset_pre_drive: busy=%b j=%b want 1/1111", busy0, j0); else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_total++; if (j0 !== 4'b0000 || k0 !== 4'b0000) $display("FAIL reset_async_jk: j=%b k=%b want 0000/0000", j0, k0); else n_pass++;
    n_total++; if (busy0 !== 1'b0 || retry0 !== 2'd0) $display("FAIL reset_async_busy: busy=%b retry=%0d want 0/0", busy0, retry0); else n_pass++;
    tick();
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++; if ({done0, err0, busy0, ready0} !== 4'b0001) $display("FAIL reset_after_%0d: done/err/busy/ready=%b want 0001", c, {done0, err0, busy0, ready0}); else n_pass++;
    end
  endtask

  task automatic test_basic();
    // Model at 0000, target 1010
    req_valid = 1'b1; req_target = 4'b1010;
    tick();  // E0
    req_valid = 1'b0;
    n_total++; if (j0 !== 4'b1010 || k0 !== 4'b0000) $display("FAIL basic_drive_jk: j=%b k=%b want 1010/0000", j0, k0); else n_pass++;
    n_total++; if (busy0 !== 1'b1 || ready0 !== 1'b0) $display("FAIL basic_busy: busy=%b ready=%b want 1/0", busy0, ready0); else n_pass++;
    tick();  // E1 -> CHECK
    n_total++; if (j0 !== 4'b0000 || k0 !== 4'b0000 || done0 !== 1'b0) $display("FAIL basic_check: j=%b k=%b done=%b want 0000/0000/0", j0, k0, done0); else n_pass++;
    n_total++; if (q0 !== 4'b1010) $display("FAIL basic_model: got %b want 1010", q0); else n_pass++;
    tick();  // E2 -> done
    n_total++; if ({done0, err0, ready0, busy0} !== 4'b1010) $display("FAIL basic_done: done/err/ready/busy=%b want 1010", {done0, err0, ready0, busy0}); else n_pass++;
    n_total++; if (retry0 !== 2'd0) $display("FAIL basic_retry: got %0d want 0", retry0); else n_pass++;
    tick();
    n_total++; if (done0 !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done0); else n_pass++;
  endtask

  task automatic test_excitation();
    // Both banks at 1010, target 0110
    req_valid = 1'b1; req_target = 4'b0110;
    tick();
    req_valid = 1'b0;
    n_total++; if (j0 !== 4'b0100 || k0 !== 4'b1000) $display("FAIL exc_setreset: j=%b k=%b want 0100/1000", j0, k0); else n_pass++;
    n_total++; if (j1 !== 4'b1100 || k1 !== 4'b1100) $display("FAIL exc_toggle: j=%b k=%b want 1100/1100", j1, k1); else n_pass++;
    tick();
    tick();
    n_total++; if (done0 !== 1'b1 || done1 !== 1'b1) $display("FAIL exc_done: done0=%b done1=%b want 1/1", done0, done1); else n_pass++;
    n_total++; if (q0 !== 4'b0110 || q1 !== 4'b0110) $display("FAIL exc_model: q0=%b q1=%b want 0110/0110", q0, q1); else n_pass++;
    tick();
  endtask

  task automatic test_stuck();
    pulse_reset();
    stuck = 4'b0001;
    req_valid = 1'b1; req_target = 4'b0001;
    tick();  // E0
    req_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      n_total++; if (j0 !== 4'b0001 || k0 !== 4'b0000 || retry0 !== 2'(a)) $display("FAIL stuck_drive%0d: j=%b k=%b retry=%0d want 0001/0000/%0d", a, j0, k0, retry0, a); else n_pass++;
      tick();  // CHECK
      n_total++; if ({busy0, done0, err0} !== 3'b100) $display("FAIL stuck_check%0d: busy/done/err=%b want 100", a, {busy0, done0, err0}); else n_pass++;
      tick();
    end
    // 8 edges after accept
    n_total++; if ({err0, done0, busy0} !== 3'b100) $display("FAIL stuck_err: err/done/busy=%b want 100", {err0, done0, busy0}); else n_pass++;
    n_total++; if (retry0 !== 2'd3) $display("FAIL stuck_retry: got %0d want 3", retry0); else n_pass++;
    tick();
    n_total++; if (err0 !== 1'b0 || retry0 !== 2'd3) $display("FAIL stuck_hold: err=%b retry=%0d want 0/3", err0, retry0); else n_pass++;
    stuck = '0;
  endtask

  task automatic test_transient();
    pulse_reset();
    stuck = 4'b0001;
    req_valid = 1'b1; req_target = 4'b0001;
    tick();  // E0
    req_valid = 1'b0;
    tick();  // E1: first update is blocked by the stuck bit
    stuck = '0;
    tick();  // E2: mismatch -> retry DRIVE
    n_total++; if (j0 !== 4'b0001 || retry0 !== 2'd1) $display("FAIL trans_retry_drive: j=%b retry=%0d want 0001/1", j0, retry0); else n_pass++;
    tick();  // E3
    n_total++; if (done0 !== 1'b0) $display("FAIL trans_early_done: got %b want 0", done0); else n_pass++;
    tick();  // E4
    n_total++; if ({done0, err0} !== 2'b10 || retry0 !== 2'd1) $display("FAIL trans_done: done/err=%b retry=%0d want 10/1", {done0, err0}, retry0); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    req_valid = 1'b1; req_target = 4'b0011;
    tick();  // E0: accept 0011
    req_target = 4'b1100;
    n_total++; if (j0 !== 4'b0011) $display("FAIL b2b_first_j: got %b want 0011", j0); else n_pass++;
    tick();  // E1
    tick();  // E2: done, ready, second accept pending
    n_total++; if ({done0, ready0} !== 2'b11 || q0 !== 4'b0011) $display("FAIL b2b_first_done: done/ready=%b q=%b want 11/0011", {done0, ready0}, q0); else n_pass++;
    tick();  // E3: second accept
    req_valid = 1'b0;
    n_total++; if (done0 !== 1'b0 || busy0 !== 1'b1 || j0 !== 4'b1100 || k0 !== 4'b0011) $display("FAIL b2b_second_drive: done=%b busy=%b j=%b k=%b want 0/1/1100/0011", done0, busy0, j0, k0); else n_pass++;
    tick();  // E4
    n_total++; if (done0 !== 1'b0) $display("FAIL b2b_gap: got %b want 0", done0); else n_pass++;
    tick();  // E5
    n_total++; if (done0 !== 1'b1 || q0 !== 4'b1100) $display("FAIL b2b_second_done: done=%b q=%b want 1/1100", done0, q0); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_excitation();
    test_stuck();
    test_transient();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want bench to finish first");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Sequencer that drives a bank of WIDTH external JK flip-flops from IDLE to a requested target value. It sits upstream of the JK flip-flop bank: it generates the J/K excitation, observes the flops' Q outputs, and verifies the result. It retries up to MAX_RETRY times before flagging an error. A valid/ready request port accepts one target at a time.

## Interface
- WIDTH, 4, number of JK flops driven.
- MAX_RETRY, 3, extra drive attempts after the first failed check (≥0).
- USE_TOGGLE, 0, 0 = set/reset excitation for changing bits; 1 = toggle excitation (J=K=1).
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_target  in  WIDTH  desired flop value; sampled on accept.
- q_fb  in  WIDTH  Q outputs of the driven flop bank.
- j_out  out  WIDTH  J inputs to the flop bank (registered).
- k_out  out  WIDTH  K inputs to the flop bank (registered).
- busy  out  1  high in DRIVE or CHECK.
- done  out  1  one-cycle pulse: target reached.
- err  out  1  one-cycle pulse: retries exhausted.
- retry_cnt  out  $clog2(MAX_RETRY+1) (min 1)  retries used by the current/last request.

## Operation
- States: IDLE, DRIVE, CHECK.
- Accept occurs on an edge with req_valid && req_ready:
  - latch req_target into tgt;
  - clear retry_cnt;
  - go to DRIVE.
- Excitation, registered on the edge entering DRIVE and computed from q_fb and tgt at that edge, per bit i:
  - q_fb[i]==tgt[i]: J=0, K=0 (hold).
  - 0→1: J=1, K=0 when USE_TOGGLE=0; J=K=1 when USE_TOGGLE=1.
  - 1→0: J=0, K=1 when USE_TOGGLE=0; J=K=1 when USE_TOGGLE=1.
- DRIVE lasts exactly 1 cycle. The next state is CHECK, and j_out/k_out return to all-zero.
- CHECK lasts 1 cycle. At its closing edge, q_fb is compared with tgt:
  - Match: go to IDLE and pulse done.
  - Mismatch and retry_cnt<MAX_RETRY: increment retry_cnt, recompute excitation from the current q_fb, go to DRIVE.
  - Mismatch and retry_cnt==MAX_RETRY: go to IDLE and pulse err.
- done and err are mutually exclusive. Each is high for exactly one cycle, the first IDLE cycle.
- A target equal to q_fb still runs DRIVE (J=K=0) then CHECK. Latency is uniform.
- req_target and q_fb changes outside their sampling edges are ignored.
- retry_cnt holds its final value in IDLE until the next accept.

## Timing
- Reset values: j_out=0, k_out=0, busy=0, done=0, err=0, retry_cnt=0, state IDLE. req_ready=1 once RST deasserts.
- RST assertion at any time takes effect immediately and asynchronously: j_out/k_out drop to 0, the request is abandoned, and no done/err is produced.
- Single attempt, with accept at edge E0:
  - E0→E1: DRIVE, j/k valid; the external flops update at E1.
  - E1→E2: CHECK.
  - E2→E3: done=1, req_ready=1.
- Each retry adds 2 cycles. The worst case is err in the cycle after edge E0+2·(MAX_RETRY+1).
- A new accept is legal in the done/err cycle. That is back-to-back operation with a 3-cycle period per successful request.
- The external flop bank is clocked by the same CLK. q_fb must be stable at the CHECK closing edge.

## Test plan
- Reset: assert RST mid-sequence, then release. Required: j_out=k_out=0, busy=0, done=err=0, retry_cnt=0, req_ready=1.
- WIDTH=4, USE_TOGGLE=0, flop model at 0000, target 1010. Required: j_out=1010, k_out=0000 for one cycle; done pulses 2 cycles after accept; model=1010; retry_cnt=0.
- From 1010, target 0110. Required with USE_TOGGLE=0: j_out=0100, k_out=1000. Required with USE_TOGGLE=1: j_out=k_out=1100. Both end with done and model=0110.
- Stuck bit: force q_fb[0]=0, target 0001, MAX_RETRY=3. Required: four DRIVE cycles with j_out=0001, then err pulse at cycle 8 after accept, retry_cnt=3, no done.
- Transient fault: q_fb[0] stuck for the first attempt only. Required: done after 4 cycles, retry_cnt=1.
- Back-to-back: hold req_valid with target 0011 then 1100. Required: second accept on the done edge of the first; done pulses 3 cycles apart; model ends 1100.
